vga_pixel_fetch: RTL and testbench
==================================

# vga_pixel_fetch

Downstream neighbour of the VGA timing generator in the bit plotter. Consumes the generator's x, y, hsync, vsync and blank. Fetches a 1-bit-per-pixel 640x480 framebuffer from memory as 32-bit words over a req/ack port, and emits a registered 8-bit colour with hsync/vsync delayed to match.

## Interface
- FG_COLOR, 8'hFF, colour for a set pixel bit (rrrgggbb)
- BG_COLOR, 8'h00, colour for a clear pixel bit and for underrun pixels
- clk  in  1  system clock; the timing generator advances x once every 2 clk
- reset  in  1  synchronous, active-high
- x  in  10  current pixel column from timing generator
- y  in  10  current line from timing generator
- hsync, vsync  in  1 each  active-low syncs from timing generator
- blank  in  1  high outside the visible 640x480 area
- mem_req  out  1  read request, held until ack
- mem_addr  out  14  word address, stable while mem_req high
- mem_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  32  read word
- out_color  out  8  registered pixel colour
- out_hsync, out_vsync  out  1 each  registered syncs, aligned with out_color
- underrun  out  1  sticky; set when a needed word was not ready

## Operation
- Framebuffer layout: linear, 20 words per line, 9600 words per frame. Pixel (x,y) is word y*20 + x/32, bit 31 - x[4:0] (MSB = leftmost pixel).
- Pixel strobe: asserted on any clk where x differs from its registered previous value. Derived internally; there is no strobe input.
- Buffering: a shift register (current word) and a one-word next buffer with a valid flag.
- Fetcher FSM, two states:
  - IDLE -> WAIT when next buffer is empty and fetch address < 9600. In the same cycle, raise mem_req with mem_addr = fetch address.
  - WAIT -> IDLE on mem_ack. Load mem_rdata into the next buffer, set valid, and increment the fetch address.
  - A new request may start the cycle after an ack.
  - mem_ack while mem_req is low is ignored.
- Word load: on a strobe with blank low and x[4:0]==0:
  - If the next buffer is valid, copy it into the shift register and clear valid.
  - If it is empty, set underrun, load the shift register with 0 (shows BG_COLOR), and leave the fetch address unchanged.
- Other visible strobes shift the register left by 1.
- Colour: out_color = blank ? 8'h00 : (pixel bit ? FG_COLOR : BG_COLOR). Pixel bit is the bit selected for the current x: for x[4:0]==0 that is the word just loaded, otherwise the shift-register MSB after the shift.
- Frame restart: on a strobe with y==480 and x==0:
  - fetch address <= 0, next valid <= 0.
  - If in WAIT, the in-flight word is discarded on its ack via a discard flag. The ack is still completed, and the address is not incremented.
  - Fetching resumes immediately, so word 0 is buffered during vertical blanking.
- Simultaneous frame restart and ack in the same cycle: restart wins and the data is discarded.
- Reset values: out_color 0, out_hsync 1, out_vsync 1, mem_req 0, mem_addr 0, underrun 0, fetch address 0, next valid 0, FSM IDLE, discard 0.
- Reset mid-frame: fetching restarts at word 0, so the image may be misaligned until the next frame restart. This is the accepted behaviour.

## Timing
- Latency: exactly 1 clk from an input x/y/hsync/vsync/blank change to the corresponding out_color/out_hsync/out_vsync.
- Memory: no constraint on ack latency. Underrun is avoided if each word arrives within 64 clk of the previous load.
- Word 0 of each line must be buffered before x==0. Horizontal blanking gives 320 clk, and the prefetch issued after the previous line's word 19 load covers it.

## Structure
- Package vga_pkg holds:
  - H_VISIBLE=640, V_VISIBLE=480, WORDS_PER_LINE=20, FRAME_WORDS=9600, FB_ADDR_WIDTH=14
  - the fetcher state enum
- Sub-module pixel_word_fetcher: FSM, fetch address counter, discard flag, next buffer and valid flag. The top level keeps the strobe detect, shift register, colour mux and sync delay.

## Test plan
- Reset then idle memory with ack one cycle after req -> mem_addr sequence 0,1,2,…; mem_req low once the next buffer is full; outputs at reset values before the first strobe.
- Word 0 = 32'h8000_0001, full frame sweep -> out_color FF at (0,0) and (31,0), 00 at (1..30,0), 1 clk after x changes.
- Blank region -> out_color 00 regardless of data; out_hsync/out_vsync equal to the inputs delayed 1 clk.
- Ack delayed 100 clk -> underrun set at x==32 of line 0, pixels 32..63 show BG_COLOR, and underrun stays high afterwards.
- Frame restart (y=480, x=0) while a request is outstanding -> that ack's data is dropped and the next mem_addr issued is 0.
- Reset asserted mid-line -> next clk all outputs at reset values; after deassert the first request uses mem_addr 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared framebuffer geometry and fetcher state encoding for the VGA pixel fetch path.
package vga_pkg;

    localparam int unsigned H_VISIBLE      = 640;
    localparam int unsigned V_VISIBLE      = 480;
    localparam int unsigned WORDS_PER_LINE = H_VISIBLE / 32;
    localparam int unsigned FRAME_WORDS    = WORDS_PER_LINE * V_VISIBLE;
    localparam int unsigned FB_ADDR_WIDTH  = 14;

    typedef enum logic [0:0] {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pixel_word_fetcher.sv
// Prefetches framebuffer words over a req/ack port into a one-word buffer,
// with frame-restart handling that drops any read already in flight.
module pixel_word_fetcher
    import vga_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_restart,
    input  logic                     i_consume,
    output logic                     o_mem_req,
    output logic [FB_ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                     i_mem_ack,
    input  logic [31:0]              i_mem_rdata,
    output logic [31:0]              o_next_word,
    output logic                     o_next_valid
);

    localparam logic [FB_ADDR_WIDTH-1:0] FRAME_END = FB_ADDR_WIDTH'(FRAME_WORDS);

    fetch_state_e             r_state;
    logic [FB_ADDR_WIDTH-1:0] r_fetch_addr;
    logic [FB_ADDR_WIDTH-1:0] r_mem_addr;
    logic                     r_mem_req;
    logic                     r_discard;
    logic                     r_next_valid;
    logic [31:0]              r_next_word;
    logic                     w_start;

    // A restart in the same cycle suppresses the launch so the stale address never goes out.
    assign w_start = (r_state == FETCH_IDLE) && !r_next_valid &&
                     (r_fetch_addr < FRAME_END) && !i_restart;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= FETCH_IDLE;
            r_fetch_addr <= '0;
            r_mem_addr   <= '0;
            r_mem_req    <= 1'b0;
            r_discard    <= 1'b0;
            r_next_valid <= 1'b0;
            r_next_word  <= '0;
        end else begin
            if (i_consume) begin
                r_next_valid <= 1'b0;
            end
            case (r_state)
                FETCH_IDLE: begin
                    if (w_start) begin
                        r_state    <= FETCH_WAIT;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fetch_addr;
                    end
                end
                FETCH_WAIT: begin
                    if (i_mem_ack) begin
                        r_state   <= FETCH_IDLE;
                        r_mem_req <= 1'b0;
                        r_discard <= 1'b0;
                        if (!r_discard && !i_restart) begin
                            r_next_word  <= i_mem_rdata;
                            r_next_valid <= 1'b1;
                            r_fetch_addr <= r_fetch_addr + FB_ADDR_WIDTH'(1);
                        end
                    end else if (i_restart) begin
                        r_discard <= 1'b1;
                    end
                end
                default: r_state <= FETCH_IDLE;
            endcase
            // Restart has the last word over address and buffer state.
            if (i_restart) begin
                r_fetch_addr <= '0;
                r_next_valid <= 1'b0;
            end
        end
    end

    assign o_mem_req    = r_mem_req;
    assign o_mem_addr   = r_mem_addr;
    assign o_next_word  = r_next_word;
    assign o_next_valid = r_next_valid;

endmodule

// File: rtl/vga_pixel_fetch.sv
// Turns timing-generator coordinates into registered 1bpp framebuffer colour,
// with syncs delayed to stay aligned with the colour output.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter logic [7:0] FG_COLOR = 8'hFF,
    parameter logic [7:0] BG_COLOR = 8'h00
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [9:0]               x,
    input  logic [9:0]               y,
    input  logic                     hsync,
    input  logic                     vsync,
    input  logic                     blank,
    output logic                     mem_req,
    output logic [FB_ADDR_WIDTH-1:0] mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    output logic [7:0]               out_color,
    output logic                     out_hsync,
    output logic                     out_vsync,
    output logic                     underrun
);

    logic [9:0]  r_x_prev;
    logic [31:0] r_shift;
    logic [7:0]  r_color;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_underrun;

    logic        w_strobe;
    logic        w_load;
    logic        w_shift;
    logic        w_restart;
    logic        w_consume;
    logic [31:0] w_next_word;
    logic        w_next_valid;
    logic [31:0] w_load_word;
    logic        w_pixel_bit;

    assign w_strobe    = (x != r_x_prev);
    assign w_load      = w_strobe && !blank && (x[4:0] == 5'd0);
    assign w_shift     = w_strobe && !blank && (x[4:0] != 5'd0);
    assign w_restart   = w_strobe && (y == 10'(V_VISIBLE)) && (x == 10'd0);
    assign w_consume   = w_load && w_next_valid;
    assign w_load_word = w_next_valid ? w_next_word : 32'h0;

    pixel_word_fetcher u_fetcher (
        .clk          (clk),
        .reset        (reset),
        .i_restart    (w_restart),
        .i_consume    (w_consume),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_ack    (mem_ack),
        .i_mem_rdata  (mem_rdata),
        .o_next_word  (w_next_word),
        .o_next_valid (w_next_valid)
    );

    // Between strobes the register MSB already holds the current pixel.
    always_comb begin
        w_pixel_bit = r_shift[31];
        if (w_load) begin
            w_pixel_bit = w_load_word[31];
        end else if (w_shift) begin
            w_pixel_bit = r_shift[30];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_prev   <= '0;
            r_shift    <= '0;
            r_color    <= 8'h00;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_underrun <= 1'b0;
        end else begin
            r_x_prev <= x;
            r_hsync  <= hsync;
            r_vsync  <= vsync;
            if (w_load) begin
                r_shift <= w_load_word;
                if (!w_next_valid) begin
                    r_underrun <= 1'b1;
                end
            end else if (w_shift) begin
                r_shift <= {r_shift[30:0], 1'b0};
            end
            r_color <= blank ? 8'h00 : (w_pixel_bit ? FG_COLOR : BG_COLOR);
        end
    end

    assign out_color = r_color;
    assign out_hsync = r_hsync;
    assign out_vsync = r_vsync;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: prefetch, pixel colour, syncs, underrun, restart, reset.
module tb_vga_pixel_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        mem_req;
    logic [13:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [7:0]  out_color;
    logic        out_hsync;
    logic        out_vsync;
    logic        underrun;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [13:0] addr_log [$];

    vga_pixel_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .hsync     (hsync),
        .vsync     (vsync),
        .blank     (blank),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .out_color (out_color),
        .out_hsync (out_hsync),
        .out_vsync (out_vsync),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [13:0] a);
        case (a)
            14'd0:   return 32'h8000_0001;
            14'd1:   return 32'hFFFF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Memory responder: acks ack_delay cycles after it first sees a request, logging each address.
    always @(posedge clk) begin
        mem_ack <= 1'b0;
        if (mem_req === 1'b1 && mem_ack !== 1'b1) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   <= 1'b1;
                mem_rdata <= mem_word(mem_addr);
                addr_log.push_back(mem_addr);
                wait_cnt  <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] nx, input logic [9:0] ny, input logic hs,
                         input logic vs, input logic bl);
        x     = nx;
        y     = ny;
        hsync = hs;
        vsync = vs;
        blank = bl;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int i = 0;
        while (addr_log.size() < n && i < budget) begin
            cyc();
            i++;
        end
        check(tag, 32'(addr_log.size() >= n), 32'd1);
    endtask

    initial begin
        int n0;
        reset = 1'b1;
        drive(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
        repeat (3) cyc();
        check("rst color", out_color, 8'h00);
        check("rst hsync", out_hsync, 1'b1);
        check("rst vsync", out_vsync, 1'b1);
        check("rst req", mem_req, 1'b0);
        check("rst addr", mem_addr, 14'd0);
        check("rst underrun", underrun, 1'b0);

        // Prefetch of word 0 during vertical blanking, then the request drops.
        reset = 1'b0;
        drive(10'd700, 10'd524, 1'b1, 1'b1, 1'b1);
        wait_log(1, 20, "first ack");
        repeat (4) cyc();
        check("first addr", addr_log[0], 14'd0);
        check("req low when full", mem_req, 1'b0);
        check("blank color pre", out_color, 8'h00);

        // Sync delay is exactly one clock.
        drive(10'd700, 10'd524, 1'b0, 1'b1, 1'b1);
        check("hsync not early", out_hsync, 1'b1);
        cyc();
        check("hsync delayed", out_hsync, 1'b0);
        drive(10'd700, 10'd524, 1'b0, 1'b0, 1'b1);
        cyc();
        check("vsync delayed", out_vsync, 1'b0);
        check("hsync held", out_hsync, 1'b0);
        drive(10'd700, 10'd524, 1'b1, 1'b1, 1'b1);
        cyc();
        check("hsync release", out_hsync, 1'b1);
        check("vsync release", out_vsync, 1'b1);

        // Line 0 with word 0 = 8000_0001.
        drive(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
        cyc();
        check("line0 x0", out_color, 8'hFF);
        cyc();
        check("line0 x0 hold", out_color, 8'hFF);
        for (int i = 1; i < 32; i++) begin
            drive(10'(i), 10'd0, 1'b1, 1'b1, 1'b0);
            cyc();
            check($sformatf("line0 x%0d", i), out_color, (i == 31) ? 8'hFF : 8'h00);
            cyc();
        end
        wait_log(2, 10, "word1 ack");
        check("second addr", addr_log[1], 14'd1);
        drive(10'd32, 10'd0, 1'b1, 1'b1, 1'b0);
        cyc();
        check("line0 x32", out_color, 8'hFF);
        cyc();
        drive(10'd33, 10'd0, 1'b1, 1'b1, 1'b0);
        cyc();
        check("line0 x33", out_color, 8'hFF);
        cyc();
        wait_log(3, 10, "word2 ack");
        check("third addr", addr_log[2], 14'd2);

        // Blanking forces 00 even though the shift register MSB is set.
        drive(10'd640, 10'd0, 1'b1, 1'b1, 1'b1);
        cyc();
        check("blank x640", out_color, 8'h00);
        cyc();
        drive(10'd650, 10'd0, 1'b1, 1'b1, 1'b1);
        cyc();
        check("blank x650", out_color, 8'h00);
        check("no underrun yet", underrun, 1'b0);

        // Frame restart while the word 3 read is outstanding.
        ack_delay = 20;
        drive(10'd64, 10'd0, 1'b1, 1'b1, 1'b0);
        cyc();
        check("line0 x64", out_color, 8'h00);
        repeat (3) cyc();
        check("outstanding req", mem_req, 1'b1);
        check("outstanding addr", mem_addr, 14'd3);
        drive(10'd0, 10'd480, 1'b1, 1'b0, 1'b1);
        cyc();
        check("restart vsync", out_vsync, 1'b0);
        wait_log(4, 40, "discarded ack");
        check("discarded addr", addr_log[3], 14'd3);
        ack_delay = 0;
        wait_log(5, 20, "restart ack");
        check("restart addr", addr_log[4], 14'd0);
        drive(10'd700, 10'd524, 1'b1, 1'b1, 1'b1);
        repeat (4) cyc();

        // Next line 0 uses word 0, not the dropped word; word 1 arrives too late.
        ack_delay = 100;
        drive(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
        cyc();
        check("restart x0", out_color, 8'hFF);
        cyc();
        for (int i = 1; i < 32; i++) begin
            drive(10'(i), 10'd0, 1'b1, 1'b1, 1'b0);
            cyc();
            cyc();
        end
        check("ur x31 color", out_color, 8'hFF);
        check("ur x31 flag", underrun, 1'b0);
        drive(10'd32, 10'd0, 1'b1, 1'b1, 1'b0);
        cyc();
        check("ur x32 color", out_color, 8'h00);
        check("ur x32 flag", underrun, 1'b1);
        cyc();
        for (int i = 33; i <= 40; i++) begin
            drive(10'(i), 10'd0, 1'b1, 1'b1, 1'b0);
            cyc();
            check($sformatf("ur x%0d", i), out_color, 8'h00);
            cyc();
        end
        check("ur sticky", underrun, 1'b1);

        // Reset mid-line with a request still outstanding.
        reset = 1'b1;
        drive(10'd40, 10'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        check("midrst color", out_color, 8'h00);
        check("midrst hsync", out_hsync, 1'b1);
        check("midrst vsync", out_vsync, 1'b1);
        check("midrst req", mem_req, 1'b0);
        check("midrst addr", mem_addr, 14'd0);
        check("midrst underrun", underrun, 1'b0);
        ack_delay = 0;
        n0 = addr_log.size();
        reset = 1'b0;
        wait_log(n0 + 1, 20, "post-reset ack");
        check("post-reset addr", addr_log[n0], 14'd0);
        check("post-reset underrun", underrun, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
